regfile_writeback: RTL and testbench

Write-back unit that owns the single write port of the 16-entry general-purpose register file. It merges results from the single-cycle ALU path and the multi-cycle memory/load path, buffers memory results in a small FIFO, and drives registered `wb_en`/`wb_rd`/`wb_data` into the register file. A busy scoreboard of outstanding loads is exported to the hazard logic.

---
 rtl/regfile_writeback.sv | 185 ++++++++++++++++++
 tb/tb_regfile_writeback.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback
// -----------------------------------------------------------------------------
// Owns the single write port of the 16-entry register file. ALU results go
// straight to the write port; memory/load results are queued in a small FIFO
// and drained on cycles where the ALU is not writing. A busy scoreboard marks
// registers with a load outstanding, from issue until the load data is written.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   alu_valid/rd/data : single-cycle ALU result, never stalled
//   mem_valid/rd/data : memory result offered to the FIFO
//   mem_ready       : FIFO can accept (combinational, !full)
//   iss_valid/rd    : load issue, sets the busy bit of its destination
//   wb_en/rd/data   : registered register-file write port
//   busy            : bit i set while a load to register i is outstanding
//   fifo_count      : FIFO occupancy, 0..DEPTH
//   addr_err        : one-cycle registered pulse for any rd >= 16
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    input  logic                       iss_valid,
    input  logic [4:0]                 iss_rd,
    output logic                       wb_en,
    output logic [4:0]                 wb_rd,
    output logic [31:0]                wb_data,
    output logic [15:0]                busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       addr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // A register index is legal only when bit 4 is clear (0..15).
    function automatic logic rd_legal(input logic [4:0] rd);
        return (rd[4] == 1'b0);
    endfunction

    // One-hot mask selecting a single scoreboard bit.
    function automatic logic [15:0] rd_mask(input logic [3:0] idx);
        return (16'd1 << idx);
    endfunction

    // FIFO storage and control
    logic [3:0]    rd_mem_r   [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Output and scoreboard registers
    logic          wb_en_r;
    logic [4:0]    wb_rd_r;
    logic [31:0]   wb_data_r;
    logic [15:0]   busy_r;
    logic          addr_err_r;

    // Per-cycle decisions
    logic          full_s;
    logic          empty_s;
    logic          alu_wr_s;
    logic          push_s;
    logic          pop_s;
    logic          err_s;
    logic [3:0]    head_rd_s;
    logic [31:0]   head_data_s;
    logic [15:0]   set_mask_s;
    logic [15:0]   clr_mask_s;
    logic [15:0]   busy_next_s;
    logic [CW-1:0] count_next_s;

    // FIFO status flags and head-of-queue view
    always_comb begin
        full_s      = (count_r == CW'(DEPTH));
        empty_s     = (count_r == {CW{1'b0}});
        head_rd_s   = rd_mem_r[rd_ptr_r];
        head_data_s = data_mem_r[rd_ptr_r];
    end

    // Arbitration, FIFO handshake, error detection and scoreboard next state.
    // An illegal memory request is still acknowledged (mem_ready ignores the
    // address) but never pushed; when full, no push happens even on a pop.
    always_comb begin
        alu_wr_s     = alu_valid && rd_legal(alu_rd);
        push_s       = mem_valid && !full_s && rd_legal(mem_rd);
        pop_s        = !alu_wr_s && !empty_s;
        err_s        = (alu_valid && !rd_legal(alu_rd))
                     || (mem_valid && !full_s && !rd_legal(mem_rd))
                     || (iss_valid && !rd_legal(iss_rd));
        set_mask_s   = 16'd0;
        clr_mask_s   = 16'd0;
        if (iss_valid && rd_legal(iss_rd)) begin
            set_mask_s = rd_mask(iss_rd[3:0]);
        end else begin
            set_mask_s = 16'd0;
        end
        if (pop_s) begin
            clr_mask_s = rd_mask(head_rd_s);
        end else begin
            clr_mask_s = 16'd0;
        end
        // A set on the same index as a clear wins.
        busy_next_s  = (busy_r & ~clr_mask_s) | set_mask_s;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO payload storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            rd_mem_r[wr_ptr_r]   <= mem_rd[3:0];
            data_mem_r[wr_ptr_r] <= mem_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Register-file write port: ALU first, then FIFO head, else hold rd/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_r   <= 1'b0;
            wb_rd_r   <= 5'd0;
            wb_data_r <= 32'd0;
        end else if (alu_wr_s) begin
            wb_en_r   <= 1'b1;
            wb_rd_r   <= alu_rd;
            wb_data_r <= alu_data;
        end else if (pop_s) begin
            wb_en_r   <= 1'b1;
            wb_rd_r   <= {1'b0, head_rd_s};
            wb_data_r <= head_data_s;
        end else begin
            wb_en_r   <= 1'b0;
        end
    end

    // Busy scoreboard and address-error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 16'd0;
            addr_err_r <= 1'b0;
        end else begin
            busy_r     <= busy_next_s;
            addr_err_r <= err_s;
        end
    end

    assign mem_ready  = !full_s;
    assign wb_en      = wb_en_r;
    assign wb_rd      = wb_rd_r;
    assign wb_data    = wb_data_r;
    assign busy       = busy_r;
    assign fifo_count = count_r;
    assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = 5'd0;
    logic [31:0] mem_data = 32'd0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = 5'd0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [15:0] busy;
    logic [2:0]  fifo_count;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .fifo_count(fifo_count), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending loads and a busy bit per register
    typedef struct { int rd; logic [31:0] data; } ent_t;
    ent_t        q[$];
    logic        exp_wb_en;
    logic [4:0]  exp_wb_rd;
    logic [31:0] exp_wb_data;
    logic [15:0] exp_busy;
    logic        exp_err;

    task automatic model_reset();
        q.delete();
        exp_wb_en = 1'b0; exp_wb_rd = 5'd0; exp_wb_data = 32'd0;
        exp_busy = 16'd0; exp_err = 1'b0;
    endtask

    task automatic drive(input logic av, input int ar, input logic [31:0] ad,
                         input logic mv, input int mr, input logic [31:0] md,
                         input logic iv, input int ir);
        alu_valid = av; alu_rd = 5'(ar); alu_data = ad;
        mem_valid = mv; mem_rd = 5'(mr); mem_data = md;
        iss_valid = iv; iss_rd = 5'(ir);
    endtask

    task automatic idle();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b0, 0);
    endtask

    // Advance one clock edge, apply the rules to the model, land on the negedge
    task automatic tick();
        bit accepted;
        ent_t e;
        @(posedge clk);
        accepted = mem_valid && (q.size() < DEPTH);
        exp_err = (alu_valid && alu_rd >= 16) || (accepted && mem_rd >= 16)
               || (iss_valid && iss_rd >= 16);
        if (alu_valid && alu_rd < 16) begin
            exp_wb_en = 1'b1; exp_wb_rd = alu_rd; exp_wb_data = alu_data;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            exp_wb_en = 1'b1; exp_wb_rd = 5'(e.rd); exp_wb_data = e.data;
            exp_busy[e.rd] = 1'b0;
        end else begin
            exp_wb_en = 1'b0;
        end
        if (accepted && mem_rd < 16) q.push_back('{int'(mem_rd), mem_data});
        if (iss_valid && iss_rd < 16) exp_busy[iss_rd] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({wb_en, wb_rd, wb_data, busy, fifo_count, addr_err, mem_ready} !== {1'b0, 5'd0, 32'd0, 16'd0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got en=%b rd=%0d data=%h busy=%h cnt=%0d err=%b rdy=%b want zeros and rdy=1",
                     wb_en, wb_rd, wb_data, busy, fifo_count, addr_err, mem_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        tick();
        checks++;
        if (wb_en !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got en=%b rdy=%b want en=0 rdy=1", wb_en, mem_ready);
        end
    endtask

    task automatic test_alu();
        drive(1'b1, 3, 32'h12345678, 1'b0, 0, 32'd0, 1'b0, 0);
        tick();
        checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h12345678) begin
            errors++;
            $display("FAIL alu_write got en=%b rd=%0d data=%h want 1/3/12345678", wb_en, wb_rd, wb_data);
        end
        idle();
        tick();
        checks++;
        if (wb_en !== 1'b0 || wb_rd !== 5'd3 || wb_data !== 32'h12345678) begin
            errors++;
            $display("FAIL alu_idle_hold got en=%b rd=%0d data=%h want 0/3/12345678", wb_en, wb_rd, wb_data);
        end
    endtask

    task automatic test_load();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 5);
        tick();
        checks++;
        if (busy !== 16'h0020) begin
            errors++;
            $display("FAIL load_busy_set got busy=%h want 0020", busy);
        end
        idle();
        repeat (3) tick();
        drive(1'b0, 0, 32'd0, 1'b1, 5, 32'h0000CAFE, 1'b0, 0);
        tick();
        checks++;
        if (wb_en !== 1'b0 || fifo_count !== 3'd1 || busy !== 16'h0020) begin
            errors++;
            $display("FAIL load_after_push got en=%b cnt=%0d busy=%h want 0/1/0020", wb_en, fifo_count, busy);
        end
        idle();
        tick();
        checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h0000CAFE || busy !== 16'h0000 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL load_write got en=%b rd=%0d data=%h busy=%h cnt=%0d want 1/5/0000cafe/0000/0",
                     wb_en, wb_rd, wb_data, busy, fifo_count);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] ad;
        for (int i = 0; i < 5; i++) begin
            ad = $urandom;
            drive(1'b1, i + 1, ad, 1'b1, 8 + i, 32'hA000 + 32'(i), 1'b0, 0);
            checks++;
            if (mem_ready !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready[%0d] got %b want %b", i, mem_ready, i < 4);
            end
            tick();
            checks++;
            if (wb_en !== 1'b1 || wb_rd !== 5'(i + 1) || wb_data !== ad) begin
                errors++;
                $display("FAIL full_alu_only[%0d] got en=%b rd=%0d data=%h want 1/%0d/%h", i, wb_en, wb_rd, wb_data, i + 1, ad);
            end
        end
        checks++;
        if (fifo_count !== 3'd4 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_count got cnt=%0d rdy=%b want 4/0", fifo_count, mem_ready);
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (wb_en !== 1'b1 || wb_rd !== 5'(8 + i) || wb_data !== 32'hA000 + 32'(i)) begin
                errors++;
                $display("FAIL drain_order[%0d] got en=%b rd=%0d data=%h want 1/%0d/%h", i, wb_en, wb_rd, wb_data, 8 + i, 32'hA000 + 32'(i));
            end
        end
        checks++;
        if (fifo_count !== 3'd0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got cnt=%0d rdy=%b want 0/1", fifo_count, mem_ready);
        end
    endtask

    task automatic test_set_wins();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 7);
        tick();
        drive(1'b1, 1, 32'h11, 1'b1, 7, 32'h77, 1'b0, 0);
        tick();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 7);
        tick();
        checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h77 || busy[7] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins got en=%b rd=%0d data=%h busy=%h want 1/7/77 busy[7]=1", wb_en, wb_rd, wb_data, busy);
        end
        idle();
        tick();
        checks++;
        if (busy[7] !== 1'b1 || wb_en !== 1'b0) begin
            errors++;
            $display("FAIL set_wins_hold got busy=%h en=%b want busy[7]=1 en=0", busy, wb_en);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 16, 32'hDEAD, 1'b1, 20, 32'hBEEF, 1'b0, 0);
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_ready got %b want 1", mem_ready);
        end
        tick();
        checks++;
        if (wb_en !== 1'b0 || fifo_count !== 3'd0 || addr_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_drop got en=%b cnt=%0d err=%b want 0/0/1", wb_en, fifo_count, addr_err);
        end
        idle();
        tick();
        checks++;
        if (wb_en !== 1'b0 || fifo_count !== 3'd0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_end got en=%b cnt=%0d err=%b want 0/0/0", wb_en, fifo_count, addr_err);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 0);
        tick();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 5);
        tick();
        drive(1'b1, 2, 32'h22, 1'b1, 0, 32'h1, 1'b0, 0);
        tick();
        drive(1'b1, 3, 32'h33, 1'b1, 5, 32'h2, 1'b0, 0);
        tick();
        checks++;
        if (fifo_count !== 3'd2 || busy !== 16'h0021 || wb_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got cnt=%0d busy=%h en=%b want 2/0021/1", fifo_count, busy, wb_en);
        end
        idle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_count !== 3'd0 || busy !== 16'h0000 || wb_en !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got cnt=%0d busy=%h en=%b rdy=%b want 0/0000/0/1", fifo_count, busy, wb_en, mem_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (wb_en !== 1'b0 || fifo_count !== 3'd0) begin
                errors++;
                $display("FAIL mid_no_stale[%0d] got en=%b cnt=%0d want 0/0", i, wb_en, fifo_count);
            end
        end
    endtask

    task automatic test_random();
        int ar, mr, ir;
        for (int n = 0; n < 600; n++) begin
            ar = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            mr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            ir = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            drive($urandom_range(0, 99) < 40, ar, $urandom,
                  $urandom_range(0, 99) < 55, mr, $urandom,
                  $urandom_range(0, 99) < 30, ir);
            checks++;
            if (mem_ready !== (q.size() < DEPTH)) begin
                errors++;
                $display("FAIL rand_ready[%0d] got %b want %b", n, mem_ready, q.size() < DEPTH);
            end
            tick();
            checks++;
            if (wb_en !== exp_wb_en || wb_rd !== exp_wb_rd || wb_data !== exp_wb_data) begin
                errors++;
                $display("FAIL rand_wb[%0d] got en=%b rd=%0d data=%h want %b/%0d/%h",
                         n, wb_en, wb_rd, wb_data, exp_wb_en, exp_wb_rd, exp_wb_data);
            end
            checks++;
            if (busy !== exp_busy || fifo_count !== 3'(q.size()) || addr_err !== exp_err) begin
                errors++;
                $display("FAIL rand_state[%0d] got busy=%h cnt=%0d err=%b want %h/%0d/%b",
                         n, busy, fifo_count, addr_err, exp_busy, q.size(), exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_fifo_full();
        test_set_wins();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
